fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding and interlock unit for the pipelined CPU. It tracks the destination register of every instruction in flight between register fetch and write-back in a DEPTH-entry shift register. For each source operand being issued it produces a forwarding select, and it raises a load-use stall when a result is not yet available. It replaces fixed two-stage EX/DM compare logic with depth-generic, priority-ordered matching that adds valid bits, load interlock, squash and a stall counter.

## Interface
- DEPTH, 3, number of tracked in-flight stages (slot 0 = EX, slot DEPTH-1 = oldest, e.g. WB)
- LOAD_LAT, 2, slots a load must travel before its data is forwardable (slot index ≥ LOAD_LAT-1 is ready)
- ZERO_REG, 31, architectural zero register; never matched
- CNT_W, 16, stall counter width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- issue_valid  in  1  instruction in RF is real (not bubble)
- issue_rd  in  5  destination register (BL drives 30)
- issue_wen  in  1  instruction writes issue_rd
- issue_load  in  1  instruction is LDUR
- src_a, src_b, src_c  in  5 each  Rn, Rm, Rd-as-source (STUR/CBZ)
- use_a, use_b, use_c  in  1 each  operand actually read
- squash  in  1  branch taken: issuing instruction becomes bubble
- stall  out  1  hold IF/RF, insert bubble into slot 0
- sel_a, sel_b, sel_c  out  $clog2(DEPTH+1)  0 = regfile, k = data from slot k-1
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Slot entry: valid, rd, wen, load. An entry "writes r" if valid & wen & rd==r & r!=ZERO_REG.
- Per source x: if !use_x or src_x==ZERO_REG, then sel_x=0. Otherwise find the lowest-index (youngest) slot k that writes src_x. If none, sel_x=0. If found and entry k is load with k < LOAD_LAT-1, then hazard_x=1. Otherwise sel_x=k+1.
- Only the youngest match is considered; an older non-load match never overrides a younger load hazard.
- stall = issue_valid & !squash & (hazard_a | hazard_b | hazard_c).
- While stall is high, sel outputs are don't-care. They are driven 0.
- Shift on every clock edge: slot[k] <= slot[k-1] for k≥1. slot[0] <= {issue_valid & !stall & !squash, issue_rd, issue_wen, issue_load}. A bubble has all fields zero.
- squash has priority over stall. A squashed instruction never stalls and enters slot 0 as a bubble.
- stall_cnt increments on each edge where stall=1 and saturates at all-ones.

## Timing
- stall and sel_* are combinational from registered slots plus current issue inputs, with a same-cycle response.
- The entry written on edge n sits in slot 0 during cycle n+1 and in slot k during cycle n+1+k. It leaves after slot DEPTH-1.
- Back-to-back dependent ALU ops give sel=1, with zero stalls.
- A dependent op directly after a load gives stall for (LOAD_LAT-1) cycles and then sel=LOAD_LAT.
- Reset, asynchronous, mid-operation: all slots become invalid, stall=0, sel_*=0, stall_cnt=0. This holds immediately, not at the next edge.
- The first edge after reset deasserts loads normally.

## Structure
- Package cpu_pipe_pkg holds:
  - the slot_t struct (valid, rd, wen, load)
  - ZERO_REG_DEF=31 and LINK_REG=30 constants
  - the SEL_W function, $clog2(DEPTH+1)
- One sub-module, fwd_match: searches the slot array for one source and returns sel and hazard. It is instantiated three times.
- The top holds the slot shift register, stall combine and counter.

## Test plan
- Reset, then ADD X1 followed by ADD using X1 as src_a: sel_a=1, stall=0. One cycle later the same source matched from slot 1 gives sel_a=2.
- LDUR X2, then ADD using src_b=X2, with LOAD_LAT=2: stall=1 for exactly 1 cycle and stall_cnt=1. Next cycle sel_b=2 and stall=0.
- Slots hold X3 in slot 1 (ALU) and X3 in slot 0 (load), with src_a=3: stall=1, the youngest load wins. No forward from slot 1.
- src_c=31 with slot 0 writing X31: sel_c=0, stall=0. BL (issue_rd=30) then STUR with src_c=30: sel_c=1.
- Hazardous LDUR dependency issued with squash=1: stall=0, slot 0 bubble, and a later matching source gives sel=0.
- Assert reset while a load sits in slot 0 and stall=1: stall and sel_* drop to 0 before the next edge. Also force stall for 2^CNT_W+5 cycles: stall_cnt holds all-ones.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the forwarding/interlock logic: slot record,
// architectural register constants and the select-width helper.
package cpu_pipe_pkg;

   localparam int          REG_W        = 5;
   localparam logic [4:0]  ZERO_REG_DEF = 5'd31;
   localparam logic [4:0]  LINK_REG     = 5'd30;

   // One in-flight instruction as seen by the forwarding network.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             wen;
      logic             load;
   } slot_t;

   // Width of a forwarding select: 0 = regfile, 1..depth = slot index + 1.
   function automatic int SEL_W(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue-side bundle between the register-fetch stage and the scoreboard.
// The RF stage (master) presents the issuing instruction; the scoreboard
// (slave) answers with stall, forwarding selects and the stall counter.
interface fwd_scoreboard_if
   import cpu_pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
);
   localparam int SW = SEL_W(DEPTH);

   logic             issue_valid;
   logic [REG_W-1:0] issue_rd;
   logic             issue_wen;
   logic             issue_load;
   logic [REG_W-1:0] src_a;
   logic [REG_W-1:0] src_b;
   logic [REG_W-1:0] src_c;
   logic             use_a;
   logic             use_b;
   logic             use_c;
   logic             squash;
   logic             stall;
   logic [SW-1:0]    sel_a;
   logic [SW-1:0]    sel_b;
   logic [SW-1:0]    sel_c;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output issue_valid, issue_rd, issue_wen, issue_load,
      output src_a, src_b, src_c, use_a, use_b, use_c, squash,
      input  stall, sel_a, sel_b, sel_c, stall_cnt
   );

   modport slave (
      input  issue_valid, issue_rd, issue_wen, issue_load,
      input  src_a, src_b, src_c, use_a, use_b, use_c, squash,
      output stall, sel_a, sel_b, sel_c, stall_cnt
   );

endinterface

// File: rtl/fwd_match.sv
// Priority search of the in-flight slots for one source operand.
// Returns the forwarding select of the youngest writer, or a hazard when
// that youngest writer is a load whose data is not yet available.
module fwd_match
   import cpu_pipe_pkg::*;
#(
   parameter int         DEPTH    = 3,
   parameter int         LOAD_LAT = 2,
   parameter logic [4:0] ZERO_REG = ZERO_REG_DEF,
   parameter int         SW       = SEL_W(DEPTH)
) (
   input  slot_t [DEPTH-1:0] slots,
   input  logic [REG_W-1:0]  src,
   input  logic              use_src,
   output logic [SW-1:0]     sel,
   output logic              hazard
);

   logic found;

   // Youngest-first scan; the first hit decides, older entries are ignored.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      sel    = '0;
      hazard = 1'b0;
      found  = 1'b0;
      if (use_src && (src != ZERO_REG)) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (!found && slots[k].valid && slots[k].wen && (slots[k].rd == src)) begin
               found = 1'b1;
               if (slots[k].load && (k < LOAD_LAT - 1))
                  hazard = 1'b1;
               else
                  sel = SW'(k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use interlock unit. Holds a DEPTH-entry shift register
// of in-flight destinations, resolves each source operand through fwd_match,
// combines hazards into a stall and counts stalled cycles (saturating).
module fwd_scoreboard
   import cpu_pipe_pkg::*;
#(
   parameter int         DEPTH    = 3,
   parameter int         LOAD_LAT = 2,
   parameter logic [4:0] ZERO_REG = ZERO_REG_DEF,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   fwd_scoreboard_if.slave  bus
);

   localparam int SW = SEL_W(DEPTH);

   slot_t [DEPTH-1:0] slot_q, slot_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [SW-1:0]     sel_a_raw, sel_b_raw, sel_c_raw;
   logic              hazard_a, hazard_b, hazard_c;
   logic              stall;
   logic              enter_valid;

   fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .SW(SW)) u_match_a (
      .slots(slot_q), .src(bus.src_a), .use_src(bus.use_a), .sel(sel_a_raw), .hazard(hazard_a)
   );
   fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .SW(SW)) u_match_b (
      .slots(slot_q), .src(bus.src_b), .use_src(bus.use_b), .sel(sel_b_raw), .hazard(hazard_b)
   );
   fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .SW(SW)) u_match_c (
      .slots(slot_q), .src(bus.src_c), .use_src(bus.use_c), .sel(sel_c_raw), .hazard(hazard_c)
   );

   // Squash wins over stall: a squashed instruction never interlocks.
   assign stall       = bus.issue_valid & ~bus.squash & (hazard_a | hazard_b | hazard_c);
   assign enter_valid = bus.issue_valid & ~stall & ~bus.squash;

   assign bus.stall     = stall;
   assign bus.sel_a     = stall ? '0 : sel_a_raw;
   assign bus.sel_b     = stall ? '0 : sel_b_raw;
   assign bus.sel_c     = stall ? '0 : sel_c_raw;
   assign bus.stall_cnt = stall_cnt_q;

   // Next slot contents: shift by one, new entry (or all-zero bubble) into slot 0.
   always_comb begin
      slot_d = '0;
      for (int k = 1; k < DEPTH; k++)
         slot_d[k] = slot_q[k-1];
      if (enter_valid)
         slot_d[0] = '{valid: 1'b1, rd: bus.issue_rd, wen: bus.issue_wen, load: bus.issue_load};
   end

   // Saturating stall counter.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // State registers; reset clears every slot so stall/sel drop immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the whole slot array is reset, not just valid bits, because stall and sel are decoded straight from it.
         slot_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every slot samples its pre-edge neighbour.
         slot_q      <= slot_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
